// File: rtl/reg_wb_arbiter_if.sv
// reg_wb_arbiter_if: register-file write-back bundle.
// Carries the primary write-back, the secondary valid/ready source and the merged write port.
//   master: drives p_valid/p_rd/p_data and s_valid/s_rd/s_data.
//           Observes p_stall, s_ready, regwrite, rd and writedata.
//   slave : the arbiter side, with every direction reversed.
interface reg_wb_arbiter_if;
  logic        p_valid;
  logic [4:0]  p_rd;
  logic [31:0] p_data;
  logic        p_stall;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  s_rd;
  logic [31:0] s_data;
  logic        regwrite;
  logic [4:0]  rd;
  logic [31:0] writedata;

  modport master (
    output p_valid,
    output p_rd,
    output p_data,
    input  p_stall,
    output s_valid,
    input  s_ready,
    output s_rd,
    output s_data,
    input  regwrite,
    input  rd,
    input  writedata
  );

  modport slave (
    input  p_valid,
    input  p_rd,
    input  p_data,
    output p_stall,
    input  s_valid,
    output s_ready,
    input  s_rd,
    input  s_data,
    output regwrite,
    output rd,
    output writedata
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: merges the in-order write-back with a FIFO-buffered long-latency source
// onto the single registered register-file write port.
// Ports:
//   clk - rising-edge clock.
//   rst - asynchronous, active-high reset.
//   wb  - reg_wb_arbiter_if.slave: primary write, secondary valid/ready, and the write port.
// Parameters:
//   DEPTH        - secondary FIFO entries; a power of two from 2 to 8.
//   STARVE_LIMIT - number of blocked cycles before a forced drain (1..15).
// Define REGWB_STARVE_GUARD_EN to add the starve counter and the one-cycle FORCE drain.
module reg_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            rst,
  reg_wb_arbiter_if.slave wb
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [4:0]  mem_rd_q   [DEPTH];
  logic [31:0] mem_data_q [DEPTH];

  ptr_t wr_ptr_q;
  ptr_t wr_ptr_d;
  ptr_t rd_ptr_q;
  ptr_t rd_ptr_d;
  cnt_t count_q;
  cnt_t count_d;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  logic        gnt_v;
  logic [4:0]  gnt_rd;
  logic [31:0] gnt_data;

  logic        regwrite_q;
  logic [4:0]  rd_q;
  logic [31:0] writedata_q;

  assign full      = (count_q == cnt_t'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = wb.s_valid && !full;
  assign head_rd   = mem_rd_q[rd_ptr_q];
  assign head_data = mem_data_q[rd_ptr_q];

  // s_ready looks only at the current count, so a pop in the same
  // cycle does not open a slot early.
  assign wb.s_ready = !full;

  // Storage needs no reset; the pointers and count are what define
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_q[wr_ptr_q]   <= wb.s_rd;
      mem_data_q[wr_ptr_q] <= wb.s_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef REGWB_STARVE_GUARD_EN

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] starve_q;
  logic [3:0] starve_d;
  logic [3:0] starve_inc;
  logic       p_stall_q;

  assign starve_inc = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    pop      = 1'b0;
    gnt_v    = 1'b0;
    gnt_rd   = wb.p_rd;
    gnt_data = wb.p_data;
    unique case (state_q)
      NORMAL: begin
        if (wb.p_valid) begin
          gnt_v = 1'b1;
        end else if (!empty) begin
          pop      = 1'b1;
          gnt_v    = 1'b1;
          gnt_rd   = head_rd;
          gnt_data = head_data;
        end
        // Count only cycles where a queued entry loses to the pipeline.
        if (empty || !wb.p_valid) begin
          starve_d = '0;
        end else begin
          starve_d = starve_inc;
          if (starve_inc == LIMIT) begin
            state_d = FORCE;
          end
        end
      end
      FORCE: begin
        // The pipeline is held by p_stall, so its request is ignored.
        if (!empty) begin
          pop      = 1'b1;
          gnt_v    = 1'b1;
          gnt_rd   = head_rd;
          gnt_data = head_data;
        end
        state_d  = NORMAL;
        starve_d = '0;
      end
      default: begin
        state_d  = NORMAL;
        starve_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= NORMAL;
      starve_q  <= '0;
      p_stall_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      p_stall_q <= (state_d == FORCE);
    end
  end

  assign wb.p_stall = p_stall_q;

`else

  // Without the guard, the primary source always wins; the queue drains
  // only in idle pipeline cycles.
  logic unused_cfg;
  assign unused_cfg = (STARVE_LIMIT > 15);

  always_comb begin
    pop      = 1'b0;
    gnt_v    = 1'b0;
    gnt_rd   = wb.p_rd;
    gnt_data = wb.p_data;
    if (wb.p_valid) begin
      gnt_v = 1'b1;
    end else if (!empty) begin
      pop      = 1'b1;
      gnt_v    = 1'b1;
      gnt_rd   = head_rd;
      gnt_data = head_data;
    end
  end

  assign wb.p_stall = 1'b0;

`endif

  // A write to x0 is consumed normally but never enables the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_q  <= 1'b0;
      rd_q        <= '0;
      writedata_q <= '0;
    end else begin
      regwrite_q <= gnt_v && (gnt_rd != 5'd0);
      if (gnt_v) begin
        rd_q        <= gnt_rd;
        writedata_q <= gnt_data;
      end
    end
  end

  assign wb.regwrite  = regwrite_q;
  assign wb.rd        = rd_q;
  assign wb.writedata = writedata_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed checks of reg_wb_arbiter with DEPTH=2, STARVE_LIMIT=4.
// The expected starvation behaviour follows REGWB_STARVE_GUARD_EN.
module tb_reg_wb_arbiter;

  logic clk;
  logic rst;

  int total;
  int passed;
  int failed;

  reg_wb_arbiter_if wb ();

  reg_wb_arbiter #(
    .DEPTH       (2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb (wb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic port(input string tag, input logic we,
                      input logic [4:0] r, input logic [31:0] d);
    chk({tag, ".regwrite"}, 32'(wb.regwrite), 32'(we));
    chk({tag, ".rd"}, 32'(wb.rd), 32'(r));
    chk({tag, ".writedata"}, wb.writedata, d);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    rst        = 1'b1;
    wb.p_valid = 1'b0;
    wb.p_rd    = '0;
    wb.p_data  = '0;
    wb.s_valid = 1'b0;
    wb.s_rd    = '0;
    wb.s_data  = '0;
    #2;
    port("reset", 1'b0, 5'd0, 32'h0);
    chk("reset.p_stall", 32'(wb.p_stall), 32'd0);
    chk("reset.s_ready", 32'(wb.s_ready), 32'd1);
    tick;
    rst = 1'b0;

    // Primary only
    wb.p_valid = 1'b1;
    wb.p_rd    = 5'd5;
    wb.p_data  = 32'hDEADBEEF;
    tick;
    port("prim5", 1'b1, 5'd5, 32'hDEADBEEF);
    wb.p_rd   = 5'd0;
    wb.p_data = 32'h12345678;
    tick;
    port("prim0", 1'b0, 5'd0, 32'h12345678);
    wb.p_valid = 1'b0;
    tick;
    port("idle", 1'b0, 5'd0, 32'h12345678);

    // Secondary drain, in order
    wb.s_valid = 1'b1;
    wb.s_rd    = 5'd7;
    wb.s_data  = 32'h11;
    tick;
    chk("drain.rdy0", 32'(wb.s_ready), 32'd1);
    chk("drain.we0", 32'(wb.regwrite), 32'd0);
    wb.s_rd   = 5'd8;
    wb.s_data = 32'h22;
    tick;
    port("drain7", 1'b1, 5'd7, 32'h11);
    chk("drain.rdy1", 32'(wb.s_ready), 32'd1);
    wb.s_valid = 1'b0;
    tick;
    port("drain8", 1'b1, 5'd8, 32'h22);
    chk("drain.rdy2", 32'(wb.s_ready), 32'd1);
    tick;
    port("drain.idle", 1'b0, 5'd8, 32'h22);

    // Backpressure with the FIFO full
    wb.p_valid = 1'b1;
    wb.p_rd    = 5'd1;
    wb.p_data  = 32'hA0;
    wb.s_valid = 1'b1;
    wb.s_rd    = 5'd9;
    wb.s_data  = 32'h33;
    tick;
    chk("bp.rdy1", 32'(wb.s_ready), 32'd1);
    port("bp.prim", 1'b1, 5'd1, 32'hA0);
    wb.s_rd   = 5'd10;
    wb.s_data = 32'h44;
    tick;
    chk("bp.rdy2", 32'(wb.s_ready), 32'd0);
    wb.s_rd   = 5'd11;
    wb.s_data = 32'h55;
    tick;
    chk("bp.rdy3", 32'(wb.s_ready), 32'd0);
    port("bp.prim2", 1'b1, 5'd1, 32'hA0);
    wb.p_valid = 1'b0;
    tick;
    port("bp.pop9", 1'b1, 5'd9, 32'h33);
    chk("bp.rdy4", 32'(wb.s_ready), 32'd1);
    tick;
    port("bp.pop10", 1'b1, 5'd10, 32'h44);
    wb.s_valid = 1'b0;
    tick;
    port("bp.pop11", 1'b1, 5'd11, 32'h55);

    // Starvation: one queued entry with a saturated pipeline
    wb.p_valid = 1'b1;
    wb.p_rd    = 5'd2;
    wb.p_data  = 32'hB0;
    wb.s_valid = 1'b1;
    wb.s_rd    = 5'd12;
    wb.s_data  = 32'h66;
    tick;
    wb.s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("starve.stall", 32'(wb.p_stall), 32'd0);
      chk("starve.rd", 32'(wb.rd), 32'd2);
    end
    tick;
`ifdef REGWB_STARVE_GUARD_EN
    chk("force.stall1", 32'(wb.p_stall), 32'd1);
    port("force.prim", 1'b1, 5'd2, 32'hB0);
    tick;
    chk("force.stall0", 32'(wb.p_stall), 32'd0);
    port("force.sec", 1'b1, 5'd12, 32'h66);
    tick;
    chk("force.stall2", 32'(wb.p_stall), 32'd0);
    port("force.resume", 1'b1, 5'd2, 32'hB0);
    wb.p_valid = 1'b0;
    tick;
    chk("force.idle", 32'(wb.regwrite), 32'd0);
`else
    chk("strict.stall1", 32'(wb.p_stall), 32'd0);
    port("strict.prim", 1'b1, 5'd2, 32'hB0);
    tick;
    chk("strict.stall2", 32'(wb.p_stall), 32'd0);
    port("strict.prim2", 1'b1, 5'd2, 32'hB0);
    wb.p_valid = 1'b0;
    tick;
    port("strict.sec", 1'b1, 5'd12, 32'h66);
    tick;
    chk("strict.idle", 32'(wb.regwrite), 32'd0);
`endif

    // Asynchronous reset with two entries queued
    wb.p_valid = 1'b1;
    wb.p_rd    = 5'd3;
    wb.p_data  = 32'hC0;
    wb.s_valid = 1'b1;
    wb.s_rd    = 5'd13;
    wb.s_data  = 32'h77;
    tick;
    wb.s_rd   = 5'd14;
    wb.s_data = 32'h88;
    tick;
    wb.s_valid = 1'b0;
    chk("rst.full", 32'(wb.s_ready), 32'd0);
    chk("rst.pre", 32'(wb.regwrite), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    port("rst.async", 1'b0, 5'd0, 32'h0);
    chk("rst.p_stall", 32'(wb.p_stall), 32'd0);
    chk("rst.s_ready", 32'(wb.s_ready), 32'd1);
    wb.p_valid = 1'b0;
    rst        = 1'b0;
    tick;
    chk("rst.post1", 32'(wb.regwrite), 32'd0);
    tick;
    port("rst.post2", 1'b0, 5'd0, 32'h0);
    wb.p_valid = 1'b1;
    wb.p_rd    = 5'd4;
    wb.p_data  = 32'hD0;
    tick;
    port("rst.new", 1'b1, 5'd4, 32'hD0);
    wb.p_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
